hammer_spin_seq: RTL and testbench

HAMMER_SPIN_SEQ -- requirements
Module: hammer_spin_seq

---
 rtl/hammer_pkg.sv | 32 +++
 rtl/hammer_spin_seq_if.sv | 24 ++
 rtl/octagon_dir_rom.sv | 24 ++
 rtl/hammer_spin_seq.sv | 153 +++++++++++++++
 tb/tb_hammer_spin_seq.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/hammer_pkg.sv
// Shared types and constants for the hammer spin sequencer.
package hammer_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SPIN    = 3'd1,
    RELEASE = 3'd2,
    FLIGHT  = 3'd3,
    LANDED  = 3'd4
  } state_t;

  localparam logic [7:0] KEY_A     = 8'h04;
  localparam logic [7:0] KEY_D     = 8'h07;
  localparam logic [7:0] KEY_S     = 8'h16;
  localparam logic [7:0] KEY_W     = 8'h1A;
  localparam logic [7:0] KEY_SPACE = 8'h2C;

  typedef logic signed [9:0] motion_t;

  // Multiply a unit direction sign (-1, 0 or +1) by an unsigned magnitude.
  function automatic motion_t scale_dir(input logic signed [1:0] d, input logic [9:0] mag);
    motion_t r;
    r = '0;
    case (d)
      2'b01:   r = $signed(mag);
      2'b11:   r = -$signed(mag);
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/hammer_spin_seq_if.sv
// Control inputs and per-frame outputs of the hammer spin sequencer.
// The release pulse is called release_pulse because "release" is a reserved word.
interface hammer_spin_seq_if;
  import hammer_pkg::*;

  logic       Run;
  logic [7:0] keycode;
  motion_t    motion_x;
  motion_t    motion_y;
  logic [2:0] state;
  logic [2:0] segment;
  logic [2:0] laps;
  logic       release_pulse;

  modport master (
    output Run, keycode,
    input  motion_x, motion_y, state, segment, laps, release_pulse
  );

  modport slave (
    input  Run, keycode,
    output motion_x, motion_y, state, segment, laps, release_pulse
  );
endinterface

// File: rtl/octagon_dir_rom.sv
// Unit direction signs for each of the eight octagon segments.
module octagon_dir_rom (
  input  logic [2:0]        segment,
  output logic signed [1:0] dx,
  output logic signed [1:0] dy
);

  // Segment index to (dx, dy), walking the octagon starting from due left.
  always_comb begin
    dx = 2'sd0;
    dy = 2'sd0;
    case (segment)
      3'd0: begin dx = -2'sd1; dy =  2'sd0; end
      3'd1: begin dx = -2'sd1; dy =  2'sd1; end
      3'd2: begin dx =  2'sd0; dy =  2'sd1; end
      3'd3: begin dx =  2'sd1; dy =  2'sd1; end
      3'd4: begin dx =  2'sd1; dy =  2'sd0; end
      3'd5: begin dx =  2'sd1; dy = -2'sd1; end
      3'd6: begin dx =  2'sd0; dy = -2'sd1; end
      default: begin dx = -2'sd1; dy = -2'sd1; end
    endcase
  end

endmodule

// File: rtl/hammer_spin_seq.sv
// Hammer-throw sequencer: keyboard walking, octagon spin, release and flight.
module hammer_spin_seq
  import hammer_pkg::*;
#(
  parameter int SEG_LEN    = 15,
  parameter int FLIGHT_LEN = 60,
  parameter int STEP       = 2
) (
  input  logic              frame_clk,
  input  logic              Reset,
  hammer_spin_seq_if.slave  bus
);

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [2:0]        seg_q, seg_d;
  logic [2:0]        laps_q, laps_d;
  logic              rel_q, rel_d;
  motion_t           fx_q, fx_d, fy_q, fy_d;
  motion_t           mx_q, mx_d, my_q, my_d;
  logic signed [1:0] cur_dx, cur_dy, nxt_dx, nxt_dy;

  // Direction of the segment being held now (latched at release).
  octagon_dir_rom u_rom_cur (.segment(seg_q), .dx(cur_dx), .dy(cur_dy));
  // Direction of the segment entered on this edge (drives spin motion).
  octagon_dir_rom u_rom_nxt (.segment(seg_d), .dx(nxt_dx), .dy(nxt_dy));

  // Next-state logic for the FSM, step counter, segment, laps and flight vector.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    seg_d   = seg_q;
    laps_d  = laps_q;
    rel_d   = 1'b0;
    fx_d    = fx_q;
    fy_d    = fy_q;
    if (!bus.Run) begin
      state_d = IDLE;
      cnt_d   = '0;
      seg_d   = '0;
      laps_d  = '0;
      fx_d    = '0;
      fy_d    = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.keycode == KEY_SPACE) begin
            state_d = SPIN;
            cnt_d   = '0;
            seg_d   = '0;
            laps_d  = '0;
          end
        end
        SPIN: begin
          if (bus.keycode != KEY_SPACE) begin
            state_d = RELEASE;
            rel_d   = 1'b1;
            cnt_d   = '0;
            fx_d    = scale_dir(cur_dx, 10'(laps_q) + 10'd1);
            fy_d    = scale_dir(cur_dy, 10'(laps_q) + 10'd1);
          end else if (cnt_q == 8'(SEG_LEN - 1)) begin
            cnt_d = '0;
            seg_d = seg_q + 3'd1;
            if (seg_q == 3'd7 && laps_q != 3'd7) begin
              laps_d = laps_q + 3'd1;
            end
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        RELEASE: begin
          state_d = FLIGHT;
          cnt_d   = '0;
        end
        FLIGHT: begin
          if (cnt_q == 8'(FLIGHT_LEN - 1)) begin
            state_d = LANDED;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        LANDED: begin
          if (bus.keycode == 8'h00) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Motion for the frame that follows this edge, derived from the next state.
  always_comb begin
    mx_d = '0;
    my_d = '0;
    if (bus.Run) begin
      case (state_d)
        IDLE: begin
          case (bus.keycode)
            KEY_A:   mx_d = -10'sd1;
            KEY_D:   mx_d =  10'sd1;
            KEY_S:   my_d =  10'sd1;
            KEY_W:   my_d = -10'sd1;
            default: ;
          endcase
        end
        SPIN: begin
          mx_d = scale_dir(nxt_dx, 10'(STEP));
          my_d = scale_dir(nxt_dy, 10'(STEP));
        end
        FLIGHT: begin
          mx_d = fx_d;
          my_d = fy_d;
        end
        default: ;
      endcase
    end
  end

  // State and registered outputs; Reset clears everything immediately.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      seg_q   <= '0;
      laps_q  <= '0;
      rel_q   <= 1'b0;
      fx_q    <= '0;
      fy_q    <= '0;
      mx_q    <= '0;
      my_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      seg_q   <= seg_d;
      laps_q  <= laps_d;
      rel_q   <= rel_d;
      fx_q    <= fx_d;
      fy_q    <= fy_d;
      mx_q    <= mx_d;
      my_q    <= my_d;
    end
  end

  assign bus.state         = state_q;
  assign bus.segment       = seg_q;
  assign bus.laps          = laps_q;
  assign bus.release_pulse = rel_q;
  assign bus.motion_x      = mx_q;
  assign bus.motion_y      = my_q;

endmodule

// File: tb/tb_hammer_spin_seq.sv
// Self-checking bench for hammer_spin_seq against a frame-count reference model.
module tb_hammer_spin_seq;
  import hammer_pkg::*;

  localparam int SEG_LEN    = 15;
  localparam int FLIGHT_LEN = 60;
  localparam int STEP       = 2;
  localparam int LAP        = 8 * SEG_LEN;

  logic frame_clk;
  logic Reset;
  int   checks;
  int   failures;

  // Octagon direction table, seg0 = due left, proceeding counter-clockwise in screen terms.
  int DX [8] = '{-1, -1, 0, 1, 1,  1,  0, -1};
  int DY [8] = '{ 0,  1, 1, 1, 0, -1, -1, -1};

  hammer_spin_seq_if bus ();

  hammer_spin_seq #(.SEG_LEN(SEG_LEN), .FLIGHT_LEN(FLIGHT_LEN), .STEP(STEP)) dut (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .bus       (bus.slave)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  task automatic applyStimulus(input logic run_i, input logic [7:0] key_i);
    bus.Run     = run_i;
    bus.keycode = key_i;
    @(posedge frame_clk);
    #1;
  endtask

  task automatic checkVal(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input state_t st, input int mx, input int my, input int rel);
    checkVal({tag, ".state"}, bus.state, st);
    checkVal({tag, ".mx"}, bus.motion_x, mx);
    checkVal({tag, ".my"}, bus.motion_y, my);
    checkVal({tag, ".rel"}, bus.release_pulse, rel);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput(tag, IDLE, 0, 0, 0);
    checkVal({tag, ".seg"}, bus.segment, 0);
    checkVal({tag, ".laps"}, bus.laps, 0);
  endtask

  // Any keycode other than none and space.
  function automatic logic [7:0] randKey();
    logic [7:0] k;
    k = 8'($urandom_range(1, 255));
    if (k == KEY_SPACE) k = 8'h2D;
    return k;
  endfunction

  // Hold space for n frames from IDLE; frame k sits in segment ((k-1)/SEG_LEN) mod 8.
  task automatic spinFrames(input int n);
    int seg, lp;
    for (int k = 1; k <= n; k++) begin
      applyStimulus(1'b1, KEY_SPACE);
      seg = ((k - 1) / SEG_LEN) % 8;
      lp  = (k - 1) / LAP;
      if (lp > 7) lp = 7;
      checkOutput("spin", SPIN, DX[seg] * STEP, DY[seg] * STEP, 0);
      checkVal("spin.seg", bus.segment, seg);
      checkVal("spin.laps", bus.laps, lp);
    end
  endtask

  // Release after n spin frames, then fly; abortAt >= 0 drops Run on that flight frame.
  task automatic releaseAndFly(input int n, input logic [7:0] relKey, input int abortAt);
    int seg, lp, fx, fy;
    seg = ((n - 1) / SEG_LEN) % 8;
    lp  = (n - 1) / LAP;
    if (lp > 7) lp = 7;
    fx = DX[seg] * (lp + 1);
    fy = DY[seg] * (lp + 1);
    applyStimulus(1'b1, relKey);
    checkOutput("release", RELEASE, 0, 0, 1);
    for (int f = 0; f < FLIGHT_LEN; f++) begin
      if (f == abortAt) begin
        applyStimulus(1'b0, KEY_SPACE);
        checkResetValues("abort");
        return;
      end
      applyStimulus(1'b1, 8'($urandom_range(0, 255)));
      checkOutput("flight", FLIGHT, fx, fy, 0);
    end
    applyStimulus(1'b1, KEY_W);
    checkOutput("landed", LANDED, 0, 0, 0);
    applyStimulus(1'b1, 8'h55);
    checkOutput("landed.hold", LANDED, 0, 0, 0);
    applyStimulus(1'b1, 8'h00);
    checkOutput("landed.exit", IDLE, 0, 0, 0);
  endtask

  initial begin
    int n, sel, ex, ey;
    logic [7:0] k;
    checks   = 0;
    failures = 0;
    Reset       = 1'b1;
    bus.Run     = 1'b0;
    bus.keycode = 8'h00;
    repeat (2) @(posedge frame_clk);
    #1;
    checkResetValues("reset");
    Reset = 1'b0;

    // Walking right for three frames.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, KEY_D);
      checkOutput("walk.d", IDLE, 1, 0, 0);
    end

    // Random walking keys and stray keycodes in IDLE.
    for (int i = 0; i < 12; i++) begin
      sel = $urandom_range(0, 4);
      ex = 0;
      ey = 0;
      case (sel)
        0: begin k = KEY_A; ex = -1; end
        1: begin k = KEY_D; ex =  1; end
        2: begin k = KEY_S; ey =  1; end
        3: begin k = KEY_W; ey = -1; end
        default: begin
          k = randKey();
          if (k == KEY_A || k == KEY_D || k == KEY_S || k == KEY_W) k = 8'h00;
        end
      endcase
      applyStimulus(1'b1, k);
      checkOutput("walk.rand", IDLE, ex, ey, 0);
    end

    // Two laps plus 20 frames, released with no key: seg1, laps 2, flight (-3,+3).
    spinFrames(2 * LAP + 20);
    releaseAndFly(2 * LAP + 20, 8'h00, -1);

    // Nine-plus laps: lap count saturates and flight magnitude reaches 8.
    n = 9 * LAP + $urandom_range(1, LAP);
    spinFrames(n);
    releaseAndFly(n, randKey(), -1);

    // Run dropped part way through flight.
    n = $urandom_range(1, 200);
    spinFrames(n);
    releaseAndFly(n, randKey(), $urandom_range(0, FLIGHT_LEN - 1));
    applyStimulus(1'b0, KEY_SPACE);
    checkResetValues("run_low.hold");
    applyStimulus(1'b1, 8'h00);
    checkOutput("run_high", IDLE, 0, 0, 0);

    // Run dropped mid-spin.
    spinFrames(40);
    applyStimulus(1'b0, KEY_SPACE);
    checkResetValues("run_low.spin");
    applyStimulus(1'b1, 8'h00);
    checkOutput("run_high2", IDLE, 0, 0, 0);

    // Asynchronous reset while in segment 5.
    spinFrames(5 * SEG_LEN + 3);
    checkVal("pre_reset.seg", bus.segment, 5);
    #2;
    Reset = 1'b1;
    #1;
    checkResetValues("async_reset");
    @(posedge frame_clk);
    #1;
    checkResetValues("async_reset.hold");
    Reset = 1'b0;
    applyStimulus(1'b1, KEY_D);
    checkOutput("after_reset", IDLE, 1, 0, 0);
    checkVal("after_reset.seg", bus.segment, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
